// File: rtl/ring_osc_pkg.sv
// Shared types and default widths for the ring-oscillator measurement blocks.
package ring_osc_pkg;

  localparam int unsigned CNT_W_DEFAULT  = 16;
  localparam int unsigned WIN_W_DEFAULT  = 16;
  localparam int unsigned SEL_W_DEFAULT  = 3;
  localparam int unsigned SETTLE_DEFAULT = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StGate,
    StDone
  } meas_state_t;

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for a slow asynchronous oscillator tap.
module ro_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  // [0],[1] form the synchronizer; [2] is the delayed copy for edge detection.
  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], din};
    end
  end

  assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ring_osc_meas_ctrl.sv
// Ring-oscillator measurement controller: settle, gate-count synchronized edges, hand off result.
module ring_osc_meas_ctrl
  import ring_osc_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEFAULT,
  parameter int unsigned WIN_W  = WIN_W_DEFAULT,
  parameter int unsigned SEL_W  = SEL_W_DEFAULT,
  parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [SEL_W-1:0] osc_sel,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ro_in,
  output logic             ro_en,
  output logic [SEL_W-1:0] ro_sel,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic [SEL_W-1:0] res_sel,
  output logic             overflow
);

  localparam int unsigned SET_W = $clog2(SETTLE + 1);
  localparam logic [SET_W-1:0] SettleLast = SET_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CntMax     = '1;

  meas_state_t      state;
  logic [SET_W-1:0] settle_cnt;
  logic [WIN_W-1:0] win_rem;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             edge_pulse;

  ro_edge_sync u_edge_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (ro_in),
    .pulse (edge_pulse)
  );

  // Working count is kept apart from res_count so an abort never disturbs the last result.
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (edge_pulse) begin
      if (cnt == CntMax) begin
        ovf_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      ro_en      <= 1'b0;
      ro_sel     <= '0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      res_count  <= '0;
      res_sel    <= '0;
      overflow   <= 1'b0;
      settle_cnt <= '0;
      win_rem    <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
    end else if (abort) begin
      state     <= StIdle;
      ro_en     <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            state      <= StSettle;
            ro_en      <= 1'b1;
            busy       <= 1'b1;
            ro_sel     <= osc_sel;
            win_rem    <= (win_len == '0) ? WIN_W'(1) : win_len;
            settle_cnt <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
          end
        end
        StSettle: begin
          if (settle_cnt == SettleLast) begin
            state <= StGate;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        StGate: begin
          cnt     <= cnt_nxt;
          ovf     <= ovf_nxt;
          win_rem <= win_rem - WIN_W'(1);
          if (win_rem == WIN_W'(1)) begin
            state     <= StDone;
            ro_en     <= 1'b0;
            res_valid <= 1'b1;
            res_count <= cnt_nxt;
            res_sel   <= ro_sel;
            overflow  <= ovf_nxt;
          end
        end
        StDone: begin
          if (res_ready) begin
            state     <= StIdle;
            busy      <= 1'b0;
            res_valid <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
// Self-checking bench for ring_osc_meas_ctrl: vector table, scoreboard and corner sequences.
module tb_ring_osc_meas_ctrl;

  localparam int SETTLE = 8;
  localparam int NV     = 6;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] win;
    int          half;
    logic [15:0] cnt;
    int          hold;
    bit          poke;
  } vec_t;

  typedef struct {
    logic [15:0] cnt;
    logic [2:0]  sel;
    logic        ovf;
    int          lat;
  } exp_t;

  logic        clk, rst, start, abort, ro_in, res_ready;
  logic [2:0]  osc_sel;
  logic [15:0] win_len;
  logic        ro_en, busy, res_valid, overflow;
  logic [2:0]  ro_sel, res_sel;
  logic [15:0] res_count;

  logic        start_s, res_ready_s;
  logic        ro_en_s, busy_s, res_valid_s, overflow_s;
  logic [2:0]  ro_sel_s, res_sel_s;
  logic [3:0]  res_count_s;

  int   n_chk = 0;
  int   n_err = 0;
  int   ro_half = 0;
  exp_t sb[$];
  vec_t vecs[NV];

  ring_osc_meas_ctrl #(.CNT_W(16), .WIN_W(16), .SEL_W(3), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .osc_sel(osc_sel),
    .win_len(win_len), .ro_in(ro_in), .ro_en(ro_en), .ro_sel(ro_sel), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count),
    .res_sel(res_sel), .overflow(overflow)
  );

  ring_osc_meas_ctrl #(.CNT_W(4), .WIN_W(16), .SEL_W(3), .SETTLE(SETTLE)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .abort(abort), .osc_sel(osc_sel),
    .win_len(win_len), .ro_in(ro_in), .ro_en(ro_en_s), .ro_sel(ro_sel_s), .busy(busy_s),
    .res_valid(res_valid_s), .res_ready(res_ready_s), .res_count(res_count_s),
    .res_sel(res_sel_s), .overflow(overflow_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Square-wave oscillator model, half period in clk cycles; 0 holds it low.
  initial begin
    int ph;
    ph = 0;
    ro_in = 1'b0;
    forever begin
      @(negedge clk);
      if (ro_half == 0) begin
        ro_in = 1'b0;
        ph = 0;
      end else begin
        ph++;
        if (ph >= ro_half) begin
          ph = 0;
          ro_in = ~ro_in;
        end
      end
    end
  end

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_ro_en"}, ro_en, 0);
    check({tag, "_ro_sel"}, ro_sel, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_count"}, res_count, 0);
    check({tag, "_res_sel"}, res_sel, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  task automatic set_osc(input int half);
    ro_half = half;
    repeat (4 * half + 6) @(posedge clk);
  endtask

  task automatic launch(input logic [2:0] sel, input logic [15:0] win, input bit sat);
    @(negedge clk);
    osc_sel = sel;
    win_len = win;
    if (sat) start_s = 1'b1;
    else start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    start_s = 1'b0;
    osc_sel = ~sel;
    win_len = 16'hffff;
  endtask

  task automatic run_one(input vec_t v);
    exp_t e, got;
    int   w, lat;
    bit   seen;
    w = (v.win == 0) ? 1 : int'(v.win);
    set_osc(v.half);
    launch(v.sel, v.win, 1'b0);
    e.cnt = v.cnt;
    e.sel = v.sel;
    e.ovf = 1'b0;
    e.lat = SETTLE + w + 1;
    sb.push_back(e);
    lat = 1;
    while (!res_valid && lat < 2000) begin
      if (lat == 2) begin
        check("run_ro_en", ro_en, 1);
        check("run_ro_sel", ro_sel, v.sel);
      end
      if (v.poke && lat == SETTLE + 2) start = 1'b1;
      if (v.poke && lat == SETTLE + 3) start = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    if (!res_valid) begin
      check("result_timeout", 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      check("unexpected_result", 1, 0);
      return;
    end
    got = sb.pop_front();
    check("res_count", res_count, got.cnt);
    check("res_sel", res_sel, got.sel);
    check("overflow", overflow, got.ovf);
    check("latency", lat, got.lat);
    check("done_ro_en", ro_en, 0);
    seen = 1'b0;
    repeat (v.hold) begin
      @(posedge clk);
      #1;
      if (!res_valid || res_count !== got.cnt || res_sel !== got.sel || ro_en || !busy)
        seen = 1'b1;
    end
    if (v.hold > 0) check("backpressure_stable", seen, 0);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("handshake_busy", busy, 0);
    check("handshake_valid", res_valid, 0);
    if (v.poke) begin
      seen = 1'b0;
      repeat (SETTLE + w + 10) begin
        @(posedge clk);
        #1;
        if (res_valid || busy) seen = 1'b1;
      end
      check("ignored_start", seen, 0);
    end
  endtask

  initial begin
    int  lat;
    bit  seen;
    vecs[0] = '{sel: 3'd5, win: 16'd100, half: 5, cnt: 16'd10, hold: 20, poke: 1'b0};
    vecs[1] = '{sel: 3'd2, win: 16'd40,  half: 2, cnt: 16'd10, hold: 0,  poke: 1'b1};
    vecs[2] = '{sel: 3'd7, win: 16'd0,   half: 0, cnt: 16'd0,  hold: 0,  poke: 1'b0};
    vecs[3] = '{sel: 3'd1, win: 16'd30,  half: 3, cnt: 16'd5,  hold: 3,  poke: 1'b0};
    vecs[4] = '{sel: 3'd3, win: 16'd1,   half: 0, cnt: 16'd0,  hold: 0,  poke: 1'b0};
    vecs[5] = '{sel: 3'd6, win: 16'd64,  half: 4, cnt: 16'd8,  hold: 0,  poke: 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    start_s = 1'b0; res_ready_s = 1'b0; osc_sel = '0; win_len = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_vals("init");

    for (int i = 0; i < NV; i++) run_one(vecs[i]);

    // Abort during SETTLE: back to idle, previous result untouched, nothing produced.
    set_osc(3);
    launch(3'd4, 16'd50, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ro_en", ro_en, 0);
    check("abort_valid", res_valid, 0);
    check("abort_keep_count", res_count, vecs[NV-1].cnt);
    check("abort_keep_sel", res_sel, vecs[NV-1].sel);
    seen = 1'b0;
    repeat (SETTLE + 70) begin
      @(posedge clk);
      #1;
      if (res_valid || busy) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);

    // Reset asserted mid-GATE.
    launch(3'd6, 16'd100, 1'b0);
    repeat (SETTLE + 5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_vals("midgate_rst");
    run_one(vecs[0]);

    // Saturation on the 4-bit counter instance.
    set_osc(2);
    launch(3'd3, 16'd200, 1'b1);
    lat = 1;
    while (!res_valid_s && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("sat_valid", res_valid_s, 1);
    check("sat_count", res_count_s, 15);
    check("sat_overflow", overflow_s, 1);
    check("sat_sel", res_sel_s, 3);
    check("sat_latency", lat, SETTLE + 201);
    res_ready_s = 1'b1;
    @(posedge clk);
    #1;
    res_ready_s = 1'b0;
    check("sat_busy", busy_s, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
